// File: rtl/solar_adc_sequencer_if.sv
// ----------------------------------------------------------------------------
// solar_adc_sequencer_if
//   Handshake bundle between the ADC sequencer and an external multiplexed ADC.
//
//   adc_start  sequencer -> ADC   one-cycle conversion start pulse
//   adc_chan   sequencer -> ADC   mux channel: 0=voltage 1=current 2=temperature
//   adc_valid  ADC -> sequencer   conversion result strobe
//   adc_data   ADC -> sequencer   conversion result, valid with adc_valid
//
//   master : the sequencer side
//   slave  : the ADC side
// ----------------------------------------------------------------------------
interface solar_adc_sequencer_if #(
    parameter int DATA_W = 12
);
    logic              adc_start;
    logic [1:0]        adc_chan;
    logic              adc_valid;
    logic [DATA_W-1:0] adc_data;

    modport master (
        output adc_start,
        output adc_chan,
        input  adc_valid,
        input  adc_data
    );

    modport slave (
        input  adc_start,
        input  adc_chan,
        output adc_valid,
        output adc_data
    );
endinterface

// File: rtl/solar_adc_sequencer.sv
// ----------------------------------------------------------------------------
// solar_adc_sequencer
//   Front end for the solar panel monitor. Scans voltage, current and
//   temperature through a multiplexed ADC, averages 2^AVG_LOG2 conversions per
//   channel, and publishes all three averages together as one frame.
//
//   clk          system clock, rising edge
//   reset        asynchronous, active-low reset
//   enable       1 = run frames back to back; 0 = stop after the current frame
//   clear_err    clears the sticky adc_timeout flag
//   adc          ADC handshake (start/chan out, valid/data in)
//   voltage      averaged voltage of the last complete frame
//   current      averaged current of the last complete frame
//   temperature  averaged temperature of the last complete frame
//   sample_valid one-cycle strobe, high while a new frame is first visible
//   adc_timeout  sticky: the ADC did not answer within TIMEOUT_CYCLES
// ----------------------------------------------------------------------------
module solar_adc_sequencer #(
    parameter int DATA_W         = 12,
    parameter int AVG_LOG2       = 2,
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  clear_err,
    solar_adc_sequencer_if.master adc,
    output logic [DATA_W-1:0]     voltage,
    output logic [DATA_W-1:0]     current,
    output logic [DATA_W-1:0]     temperature,
    output logic                  sample_valid,
    output logic                  adc_timeout
);
    localparam int ACC_W = DATA_W + AVG_LOG2;
    localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int SMP_W = AVG_LOG2 + 1;

    localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [TMO_W-1:0] WAIT_LAST   = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [SMP_W-1:0] SAMP_LAST   = SMP_W'((1 << AVG_LOG2) - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_START,
        S_WAIT,
        S_UPDATE
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [1:0]        chan;
    logic [SET_W-1:0]  settle_cnt;
    logic [TMO_W-1:0]  wait_cnt;
    logic [SMP_W-1:0]  samp_cnt;
    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  acc_sum;
    logic [DATA_W-1:0] avg_new;
    logic [DATA_W-1:0] sh_volt;
    logic [DATA_W-1:0] sh_curr;
    logic              accept;
    logic              chan_done;
    logic              frame_done;
    logic              tmo_hit;

    // Average by truncating shift; the accumulator is wide enough that the
    // shifted value always fits DATA_W.
    function automatic logic [DATA_W-1:0] avg_trunc(input logic [ACC_W-1:0] sum);
        return DATA_W'(sum >> AVG_LOG2);
    endfunction

    assign acc_sum    = acc + ACC_W'(adc.adc_data);
    assign avg_new    = avg_trunc(acc_sum);
    assign frame_done = chan_done && (chan == 2'd2);

    assign adc.adc_start = (state == S_START);
    assign adc.adc_chan  = chan;

    // ---- state register ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ---- next-state / control decode ----
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        chan_done  = 1'b0;
        tmo_hit    = 1'b0;
        case (state)
            S_IDLE: begin
                if (enable) state_next = S_SETTLE;
            end
            S_SETTLE: begin
                if (settle_cnt == SETTLE_LAST) state_next = S_START;
            end
            S_START: begin
                state_next = S_WAIT;
            end
            S_WAIT: begin
                if (adc.adc_valid) begin
                    accept = 1'b1;
                    if (samp_cnt == SAMP_LAST) begin
                        chan_done  = 1'b1;
                        state_next = (chan == 2'd2) ? S_UPDATE : S_SETTLE;
                    end else begin
                        // Same channel: the mux is already settled.
                        state_next = S_START;
                    end
                end else if (wait_cnt == WAIT_LAST) begin
                    tmo_hit    = 1'b1;
                    state_next = enable ? S_SETTLE : S_IDLE;
                end
            end
            S_UPDATE: begin
                state_next = enable ? S_SETTLE : S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // ---- counters, accumulator, shadows and frame outputs ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            chan         <= '0;
            settle_cnt   <= '0;
            wait_cnt     <= '0;
            samp_cnt     <= '0;
            acc          <= '0;
            sh_volt      <= '0;
            sh_curr      <= '0;
            voltage      <= '0;
            current      <= '0;
            temperature  <= '0;
            sample_valid <= 1'b0;
            adc_timeout  <= 1'b0;
        end else begin
            settle_cnt <= (state == S_SETTLE && state_next == S_SETTLE)
                          ? settle_cnt + SET_W'(1) : '0;
            wait_cnt   <= (state == S_WAIT && state_next == S_WAIT)
                          ? wait_cnt + TMO_W'(1) : '0;

            if (accept) begin
                if (chan_done) begin
                    acc      <= '0;
                    samp_cnt <= '0;
                end else begin
                    acc      <= acc_sum;
                    samp_cnt <= samp_cnt + SMP_W'(1);
                end
            end else if (tmo_hit) begin
                acc      <= '0;
                samp_cnt <= '0;
            end

            // Temperature has no shadow: it is the last channel, so its
            // average goes straight to the output together with the other two.
            // Shadows touched by an aborted frame are always rewritten before
            // the next publish, so they never leak to the outputs.
            if (chan_done) begin
                case (chan)
                    2'd0:    sh_volt <= avg_new;
                    2'd1:    sh_curr <= avg_new;
                    default: ;
                endcase
            end

            // Publish on the edge into UPDATE so the new frame and its strobe
            // are visible during the UPDATE cycle itself.
            sample_valid <= frame_done;
            if (frame_done) begin
                voltage     <= sh_volt;
                current     <= sh_curr;
                temperature <= avg_new;
            end

            if (chan_done && chan != 2'd2) begin
                chan <= chan + 2'd1;
            end else if (tmo_hit || (state != S_SETTLE && state_next == S_SETTLE)) begin
                chan <= '0;
            end

            // A new timeout wins over a simultaneous clear.
            if (tmo_hit) begin
                adc_timeout <= 1'b1;
            end else if (clear_err) begin
                adc_timeout <= 1'b0;
            end
        end
    end
endmodule
